// File: rtl/enc_pkg.sv
// rtl/enc_pkg.sv - shared widths, FSM state type and popcount helper for the index encoder
package enc_pkg;

  localparam int ENC_MASK_W = 64;
  localparam int ENC_IDX_W  = 6;
  localparam int ENC_CNT_W  = 7;

  typedef enum logic [0:0] {
    ENC_IDLE  = 1'b0,
    ENC_DRAIN = 1'b1
  } enc_state_t;

  // Number of set bits in a mask; 7 bits so that an all-ones mask (64) fits.
  function automatic logic [ENC_CNT_W-1:0] enc_popcount(input logic [ENC_MASK_W-1:0] m);
    logic [ENC_CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < ENC_MASK_W; i++) begin
      cnt = cnt + {{(ENC_CNT_W-1){1'b0}}, m[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/pri_enc_64_6.sv
// rtl/pri_enc_64_6.sv - combinational search for the first set mask bit at or after start, wrapping 63->0
module pri_enc_64_6
  import enc_pkg::*;
(
  input  logic [ENC_MASK_W-1:0] mask,
  input  logic [ENC_IDX_W-1:0]  start,
  output logic [ENC_IDX_W-1:0]  idx,
  output logic                  any
);

  // Scan offsets from farthest to nearest so the bit closest to start wins.
  always_comb begin
    logic [ENC_IDX_W-1:0] pos;
    pos = '0;
    idx = '0;
    any = 1'b0;
    for (int i = ENC_MASK_W - 1; i >= 0; i--) begin
      pos = start + ENC_IDX_W'(i);
      if (mask[pos]) begin
        idx = pos;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/index_encoder_64_6.sv
// rtl/index_encoder_64_6.sv - serialises a 64-bit mask into 6-bit indices; ENC_ROUND_ROBIN_EN selects rotating search
module index_encoder_64_6
  import enc_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [ENC_MASK_W-1:0] load_mask,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ENC_IDX_W-1:0]  out_index,
  output logic                  out_last,
  output logic [ENC_CNT_W-1:0]  pend_count
);

  enc_state_t            r_state;
  enc_state_t            w_next_state;
  logic [ENC_MASK_W-1:0] r_pending;
  logic [ENC_CNT_W-1:0]  r_pend_count;
  logic [ENC_IDX_W-1:0]  w_start;
  logic [ENC_IDX_W-1:0]  w_idx;
  logic                  w_any;
  logic                  w_load;
  logic                  w_fire;

  pri_enc_64_6 u_pri_enc (
    .mask  (r_pending),
    .start (w_start),
    .idx   (w_idx),
    .any   (w_any)
  );

  assign load_ready = (r_state == ENC_IDLE);
  assign out_valid  = (r_state == ENC_DRAIN) && w_any;
  assign out_index  = out_valid ? w_idx : '0;
  assign out_last   = out_valid && (r_pend_count == ENC_CNT_W'(1));
  assign pend_count = r_pend_count;

  // An all-zero mask is accepted but never leaves IDLE.
  assign w_load = load_ready && load_valid && (load_mask != '0);
  assign w_fire = out_valid && out_ready;

`ifdef ENC_ROUND_ROBIN_EN
  logic [ENC_IDX_W-1:0] r_rr_ptr;

  // Pointer moves just past each accepted index and survives across loads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
    end else if (w_fire) begin
      r_rr_ptr <= w_idx + ENC_IDX_W'(1);
    end
  end

  assign w_start = r_rr_ptr;
`else
  assign w_start = '0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ENC_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state: enter DRAIN on a non-empty load, return to IDLE after the last index.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ENC_IDLE:  if (w_load) w_next_state = ENC_DRAIN;
      ENC_DRAIN: if (w_fire && out_last) w_next_state = ENC_IDLE;
      default:   w_next_state = ENC_IDLE;
    endcase
  end

  // Pending mask and count: captured on load, one bit retired per accepted index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending    <= '0;
      r_pend_count <= '0;
    end else if (w_load) begin
      r_pending    <= load_mask;
      r_pend_count <= enc_popcount(load_mask);
    end else if (w_fire) begin
      r_pending    <= r_pending & ~({{(ENC_MASK_W-1){1'b0}}, 1'b1} << w_idx);
      r_pend_count <= r_pend_count - ENC_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_index_encoder_64_6.sv
// tb/tb_index_encoder_64_6.sv - scoreboard bench for index_encoder_64_6
module tb_index_encoder_64_6;

  typedef struct {
    logic [5:0] idx;
    logic       last;
    logic [6:0] cnt;
  } exp_t;

`ifdef ENC_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [63:0] load_mask = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [5:0]  out_index;
  logic        out_last;
  logic [6:0]  pend_count;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];
  logic [5:0] tb_ptr = '0;

  always #5 clk = ~clk;

  index_encoder_64_6 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_mask  (load_mask),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_index  (out_index),
    .out_last   (out_last),
    .pend_count (pend_count)
  );

  // Reference order: repeated search from the model pointer over the remaining bits.
  task automatic push_model(input logic [63:0] m);
    logic [63:0] rem_m;
    int          rem;
    logic [5:0]  p;
    logic [5:0]  pick;
    bit          found;
    exp_t        e;
    rem_m = m;
    rem = 0;
    for (int i = 0; i < 64; i++) if (m[i]) rem++;
    while (rem > 0) begin
      found = 1'b0;
      pick = '0;
      for (int k = 0; k < 64; k++) begin
        p = tb_ptr + 6'(k);
        if (!found && rem_m[p]) begin
          pick = p;
          found = 1'b1;
        end
      end
      e.idx = pick;
      e.last = (rem == 1);
      e.cnt = 7'(rem);
      sb.push_back(e);
      rem_m[pick] = 1'b0;
      if (RR) tb_ptr = pick + 6'd1;
      rem--;
    end
  endtask

  task automatic do_load(input logic [63:0] m);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!load_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (!load_ready) begin
      n_fail++;
      $display("FAIL load_ready_wait: load_ready=%0b required 1", load_ready);
    end
    load_valid = 1'b1;
    load_mask  = m;
    push_model(m);
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    load_mask  = '0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== (m != '0)) begin
      n_fail++;
      $display("FAIL load_latency: out_valid=%0b required %0b", out_valid, (m != '0));
    end
  endtask

  // Hold off for 'stall' cycles, then accept up to n_max indices, comparing each against the scoreboard.
  task automatic drain(input int stall, input int n_max);
    exp_t e;
    int   taken;
    int   budget;
    out_ready = 1'b0;
    for (int s = 0; s < stall; s++) begin
      n_checks++;
      if (sb.size() == 0 || out_valid !== 1'b1 || out_index !== sb[0].idx || pend_count !== sb[0].cnt) begin
        n_fail++;
        $display("FAIL stall_hold: valid=%0b idx=%0d cnt=%0d required valid=1 idx=%0d cnt=%0d",
                 out_valid, out_index, pend_count,
                 (sb.size() != 0) ? sb[0].idx : 6'd0, (sb.size() != 0) ? sb[0].cnt : 7'd0);
      end
      @(posedge clk);
      #1;
      @(negedge clk);
    end
    out_ready = 1'b1;
    taken = 0;
    budget = 0;
    while (taken < n_max && sb.size() != 0 && budget < 200) begin
      if (out_valid) begin
        e = sb.pop_front();
        n_checks++;
        if (out_index !== e.idx || out_last !== e.last || pend_count !== e.cnt) begin
          n_fail++;
          $display("FAIL drain_out: idx=%0d last=%0b cnt=%0d required idx=%0d last=%0b cnt=%0d",
                   out_index, out_last, pend_count, e.idx, e.last, e.cnt);
        end
        taken++;
      end
      budget++;
      @(posedge clk);
      #1;
      if (taken < n_max && sb.size() != 0) @(negedge clk);
    end
    out_ready = 1'b0;
    if (budget >= 200) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d outputs still expected", sb.size());
    end
    if (sb.size() == 0) begin
      @(negedge clk);
      n_checks++;
      if (load_ready !== 1'b1 || out_valid !== 1'b0 || pend_count !== 7'd0) begin
        n_fail++;
        $display("FAIL drain_done: load_ready=%0b out_valid=%0b cnt=%0d required 1 0 0",
                 load_ready, out_valid, pend_count);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (load_ready !== 1'b1 || out_valid !== 1'b0 || out_index !== 6'd0 ||
        out_last !== 1'b0 || pend_count !== 7'd0) begin
      n_fail++;
      $display("FAIL reset_state: ready=%0b valid=%0b idx=%0d last=%0b cnt=%0d required 1 0 0 0 0",
               load_ready, out_valid, out_index, out_last, pend_count);
    end
    rst_n = 1'b1;
    tb_ptr = '0;
  endtask

  task automatic test_single();
    do_load(64'h1);
    drain(0, 64);
  endtask

  task automatic test_sparse();
    do_load((64'h1 << 3) | (64'h1 << 5) | (64'h1 << 63));
    drain(0, 64);
  endtask

  task automatic test_backpressure();
    do_load((64'h1 << 7) | (64'h1 << 9));
    drain(5, 64);
  endtask

  task automatic test_zero_and_full();
    do_load(64'h0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0 || load_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL zero_mask: out_valid=%0b load_ready=%0b required 0 1", out_valid, load_ready);
      end
    end
    do_load({64{1'b1}});
    n_checks++;
    if (pend_count !== 7'd64) begin
      n_fail++;
      $display("FAIL full_count: pend_count=%0d required 64", pend_count);
    end
    drain(0, 64);
  endtask

  task automatic test_busy_load_ignored();
    do_load((64'h1 << 1) | (64'h1 << 2));
    load_valid = 1'b1;
    load_mask  = 64'h8000_0000_0000_0000;
    drain(0, 64);
    load_valid = 1'b0;
    load_mask  = '0;
  endtask

  task automatic test_reset_mid_drain();
    do_load((64'h1 << 4) | (64'h1 << 12) | (64'h1 << 30) | (64'h1 << 50));
    drain(0, 2);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || load_ready !== 1'b1 || pend_count !== 7'd0) begin
      n_fail++;
      $display("FAIL async_reset: valid=%0b ready=%0b cnt=%0d required 0 1 0",
               out_valid, load_ready, pend_count);
    end
    sb.delete();
    tb_ptr = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_round_robin();
    do_load((64'h1 << 5) | (64'h1 << 10));
    drain(0, 64);
    do_load((64'h1 << 3) | (64'h1 << 20));
    n_checks++;
    if (out_index !== 6'd20) begin
      n_fail++;
      $display("FAIL rr_first: out_index=%0d required 20", out_index);
    end
    drain(0, 64);
  endtask

  initial begin
    test_reset();
    test_single();
    test_sparse();
    test_backpressure();
    test_zero_and_full();
    test_busy_load_ignored();
    test_reset_mid_drain();
    test_sparse();
`ifdef ENC_ROUND_ROBIN_EN
    test_reset();
    test_round_robin();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
